mem_size_probe: RTL
===================

# mem_size_probe

Parametrised memory sizing and clearing engine for the SDRAM/DDR helper path.
- On `start`, writes signature words at power-of-two probe addresses and then reads them back. Address aliasing shows how much memory is fitted, reported as a per-probe `present` mask and a `size_log2` value.
- Optionally zero-fills the detected range afterwards, so the next core starts with clean RAM.
- Drives a single-port word memory controller through the existing `rd`/`we`/`ready` pulse handshake, and feeds `present` into the OSD menu mask.

## Interface
Parameters:
- `AW`, 25: word address width.
- `DW`, 16: data width.
- `NPROBE`, 3: number of probe points, 1..8.
- `BASE_BIT`, 22: decoy address bit; requires BASE_BIT+NPROBE <= AW.
- `SIG_BASE`, 16'h0408: signature seed; sig(k) = SIG_BASE*(k+1) truncated to DW; decoy word = ~SIG_BASE.
- `CLEAR`, 1: 1 runs the zero-fill after probing; 0 skips it.

Ports:
- `clk_sys` in 1: single clock for all logic.
- `reset_n` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle request; ignored while `busy`.
- `mem_addr` out AW: access address.
- `mem_din` out DW: write data.
- `mem_dout` in DW: read data, valid when `mem_ready` returns high after a read.
- `mem_we` out 1: one-cycle write strobe.
- `mem_rd` out 1: one-cycle read strobe.
- `mem_ready` in 1: controller idle / last access complete.
- `busy` out 1: sequence in progress.
- `done` out 1: probe result valid; held until the next `start`.
- `present` out NPROBE: bit k set when probe k read back correctly.
- `size_log2` out 6: log2 of detected words; 0 when none detected.
- `error` out 1: `present[0]` = 0, i.e. memory smaller than 2^(BASE_BIT+1) words or absent.
- `clear_done` out 1: zero-fill finished; held until the next `start`.

## Operation
- Probe addresses: P(0) = 0; P(k) = 1<<(BASE_BIT+k) for k = 1..NPROBE-1. Decoy address D = 1<<BASE_BIT.
- Access order, one access at a time:
  - write sig(k) to P(k) for k = NPROBE-1 down to 0;
  - write the decoy word to D;
  - read P(k) for k = NPROBE-1 down to 0, setting `present[k]` = (mem_dout == sig(k)).
- States: IDLE, ISSUE, GAP, WAIT, NEXT, CLEAR_ISSUE, CLEAR_GAP, CLEAR_WAIT, FINISH.
- Each access:
  - ISSUE is entered only with `mem_ready` = 1 and drives addr/din plus one strobe for exactly one cycle.
  - GAP holds one cycle unconditionally, because ready may lag.
  - WAIT loops until `mem_ready` = 1; read data is captured on that cycle.
- h = number of contiguous ones in `present` starting at bit 0.
  - If h = 0: `size_log2` = 0 and `error` = 1.
  - Otherwise `size_log2` = BASE_BIT + h.
  - `size_log2` updates in the cycle after the last read completes; `done` rises in the same cycle.
- Zero-fill (CLEAR = 1 and `error` = 0):
  - writes 0 to addresses 0 .. 2^size_log2 - 1 in ascending order, one handshake each;
  - the address counter is AW+1 bits wide, so the terminal count has no wrap hazard;
  - `clear_done` rises after the final write completes.
- Zero-fill skipped (CLEAR = 0 or `error` = 1): `clear_done` rises together with `done`.
- Probe locations are overwritten by the fill; with the fill skipped, signatures remain in memory.
- `start` while `busy` is ignored.
- `start` while idle clears `done`, `clear_done`, `present`, `error` and `size_log2` in the same edge, then begins probing.

## Timing
- Reset values (asserted immediately on `reset_n` low, asynchronous):
  - `mem_we` = `mem_rd` = 0, `mem_addr` = 0, `mem_din` = 0;
  - `busy` = `done` = `clear_done` = `error` = 0, `present` = 0, `size_log2` = 0;
  - state = IDLE.
- Reset mid-access: the strobe drops immediately and no further access is issued. A following `start` restarts from the first probe write.
- Minimum 3 cycles per access when `mem_ready` stays high. Full probe = (2*NPROBE+1) accesses; defaults give 7 accesses = 21 cycles, then `done` at cycle 22 after `start`.
- `busy` rises the cycle after `start` is sampled and falls in the cycle `clear_done` rises.
- Strobes are never asserted on consecutive cycles; `mem_addr`/`mem_din` stay stable from ISSUE through the end of WAIT.

## Test plan
- Full memory, 2^25 words (no aliasing), defaults -> `present` = 3'b111, `size_log2` = 25, `error` = 0; write order 0x1000000, 0x800000, 0x000000, 0x400000 with data 0x0C18, 0x0810, 0x0408, 0xFBF7.
- Aliasing model, 2^24 words (bit 24 ignored) -> `present` = 3'b011, `size_log2` = 24; model 2^23 words -> `present` = 3'b001, `size_log2` = 23.
- Model 2^22 words (decoy aliases to 0) -> `present` = 3'b000, `size_log2` = 0, `error` = 1, no fill writes, `clear_done` together with `done`.
- AW = 8, BASE_BIT = 4, NPROBE = 2, memory of 64 words preset to 0xFFFF -> `size_log2` = 6, exactly 64 zero writes to 0..63, all 64 words read back 0, `clear_done` = 1.
- `mem_ready` held low for 5 random cycles per access -> results identical to the no-stall run; strobes one cycle wide; address stable throughout each access.
- `reset_n` pulsed low during the fill at address 20 -> all outputs zero immediately; a new `start` re-probes and completes a full fill; a `start` pulsed while `busy` has no effect.

Source files
------------

// File: rtl/mem_size_probe.sv
// Memory sizing engine: writes signatures at power-of-two probe addresses, reads them back
// to detect aliasing, reports the fitted size, then optionally zero-fills the detected range.
module mem_size_probe #(
  parameter int              AW       = 25,
  parameter int              DW       = 16,
  parameter int              NPROBE   = 3,
  parameter int              BASE_BIT = 22,
  parameter logic [DW-1:0]   SIG_BASE = 16'h0408,
  parameter bit              CLEAR    = 1'b1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_din,
  input  logic [DW-1:0]     mem_dout,
  output logic              mem_we,
  output logic              mem_rd,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [NPROBE-1:0] present,
  output logic [5:0]        size_log2,
  output logic              error,
  output logic              clear_done
);

  typedef enum logic [3:0] {
    IDLE, ISSUE, GAP, WAIT, NEXT, CLEAR_ISSUE, CLEAR_GAP, CLEAR_WAIT, FINISH
  } state_t;

  localparam logic [4:0]    NP5        = 5'(NPROBE);
  localparam logic [4:0]    LAST_STEP  = 5'(2 * NPROBE);
  localparam logic [AW-1:0] DECOY_ADDR = AW'(1) << BASE_BIT;
  localparam logic [DW-1:0] DECOY_DATA = ~SIG_BASE;

  // Probe tables padded to 8 entries so a 3-bit index always lands in range.
  logic [AW-1:0] probe_addr [8];
  logic [DW-1:0] probe_sig  [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_probe
      if (gi < NPROBE) begin : g_used
        assign probe_addr[gi] = (gi == 0) ? '0 : (AW'(1) << (BASE_BIT + gi));
        assign probe_sig[gi]  = DW'(SIG_BASE * (gi + 1));
      end else begin : g_unused
        assign probe_addr[gi] = '0;
        assign probe_sig[gi]  = '0;
      end
    end
  endgenerate

  state_t        state_reg, state_next;
  logic [4:0]    step_reg, step_next;
  logic [AW:0]   clr_addr_reg, clr_addr_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [DW-1:0] din_reg, din_next;
  logic          we_reg, we_next, rd_reg, rd_next;
  logic          busy_reg, busy_next, done_reg, done_next;
  logic          clear_done_reg, clear_done_next, error_reg, error_next;
  logic [7:0]    present_reg, present_next;
  logic [5:0]    size_reg, size_next;
  logic [2:0]    rd_idx, acc_idx;
  logic [3:0]    hits;
  logic [AW:0]   clr_limit, clr_inc;

  // Length of the run of ones starting at bit 0.
  function automatic logic [3:0] run_length(input logic [7:0] p);
    logic [3:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (run && p[i]) n = n + 4'd1;
      else             run = 1'b0;
    end
    return n;
  endfunction

  assign clr_limit = {{AW{1'b0}}, 1'b1} << size_reg;
  assign clr_inc   = clr_addr_reg + {{AW{1'b0}}, 1'b1};

  always_comb begin
    state_next      = state_reg;
    step_next       = step_reg;
    clr_addr_next   = clr_addr_reg;
    addr_next       = addr_reg;
    din_next        = din_reg;
    we_next         = 1'b0;
    rd_next         = 1'b0;
    busy_next       = busy_reg;
    done_next       = done_reg;
    clear_done_next = clear_done_reg;
    error_next      = error_reg;
    present_next    = present_reg;
    size_next       = size_reg;
    rd_idx          = 3'(LAST_STEP - step_reg);
    acc_idx         = '0;
    hits            = '0;

    case (state_reg)
      IDLE, FINISH: begin
        state_next = IDLE;
        if (start) begin
          busy_next       = 1'b1;
          done_next       = 1'b0;
          clear_done_next = 1'b0;
          error_next      = 1'b0;
          present_next    = '0;
          size_next       = '0;
          step_next       = '0;
          state_next      = mem_ready ? ISSUE : NEXT;
        end
      end
      NEXT:  if (mem_ready) state_next = ISSUE;
      ISSUE: state_next = GAP;
      GAP:   state_next = WAIT;
      WAIT: begin
        if (mem_ready) begin
          if (step_reg > NP5) present_next[rd_idx] = (mem_dout == probe_sig[rd_idx]);
          if (step_reg == LAST_STEP) begin
            hits       = run_length(present_next);
            done_next  = 1'b1;
            error_next = (hits == 4'd0);
            size_next  = (hits == 4'd0) ? 6'd0 : 6'(BASE_BIT) + {2'b00, hits};
            if (CLEAR && hits != 4'd0) begin
              clr_addr_next = '0;
              state_next    = CLEAR_ISSUE;
            end else begin
              clear_done_next = 1'b1;
              busy_next       = 1'b0;
              state_next      = FINISH;
            end
          end else begin
            step_next  = step_reg + 5'd1;
            state_next = ISSUE;
          end
        end
      end
      CLEAR_ISSUE: state_next = CLEAR_GAP;
      CLEAR_GAP:   state_next = CLEAR_WAIT;
      CLEAR_WAIT: begin
        if (mem_ready) begin
          if (clr_inc == clr_limit) begin
            clear_done_next = 1'b1;
            busy_next       = 1'b0;
            state_next      = FINISH;
          end else begin
            clr_addr_next = clr_inc;
            state_next    = CLEAR_ISSUE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Address/data are loaded only on entry to an issue state and held until the next one.
    if (state_next == ISSUE) begin
      if (step_next < NP5) begin
        acc_idx   = 3'(NP5 - 5'd1 - step_next);
        addr_next = probe_addr[acc_idx];
        din_next  = probe_sig[acc_idx];
        we_next   = 1'b1;
      end else if (step_next == NP5) begin
        addr_next = DECOY_ADDR;
        din_next  = DECOY_DATA;
        we_next   = 1'b1;
      end else begin
        acc_idx   = 3'(LAST_STEP - step_next);
        addr_next = probe_addr[acc_idx];
        rd_next   = 1'b1;
      end
    end else if (state_next == CLEAR_ISSUE) begin
      addr_next = clr_addr_next[AW-1:0];
      din_next  = '0;
      we_next   = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      step_reg       <= '0;
      clr_addr_reg   <= '0;
      addr_reg       <= '0;
      din_reg        <= '0;
      we_reg         <= 1'b0;
      rd_reg         <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      clear_done_reg <= 1'b0;
      error_reg      <= 1'b0;
      present_reg    <= '0;
      size_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      step_reg       <= step_next;
      clr_addr_reg   <= clr_addr_next;
      addr_reg       <= addr_next;
      din_reg        <= din_next;
      we_reg         <= we_next;
      rd_reg         <= rd_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      clear_done_reg <= clear_done_next;
      error_reg      <= error_next;
      present_reg    <= present_next;
      size_reg       <= size_next;
    end
  end

  assign mem_addr   = addr_reg;
  assign mem_din    = din_reg;
  assign mem_we     = we_reg;
  assign mem_rd     = rd_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign clear_done = clear_done_reg;
  assign error      = error_reg;
  assign present    = present_reg[NPROBE-1:0];
  assign size_log2  = size_reg;

endmodule
